// File: rtl/track_section_scheduler_if.sv
// Train-side bundle for track_section_scheduler; master = trains/bench, slave = scheduler.
// The fault_clr signal only exists when SCHED_FAULT_CLEAR_EN is defined.
interface track_section_scheduler_if #(
  parameter int NUM_TRAINS = 4
);
  logic [NUM_TRAINS-1:0] req;
  logic [NUM_TRAINS-1:0] exit_ack;
  logic [NUM_TRAINS-1:0] train_dir;
  logic [1:0]            track_condition;
  logic                  alert;
`ifdef SCHED_FAULT_CLEAR_EN
  logic                  fault_clr;
`endif
  logic [NUM_TRAINS-1:0] grant;
  logic                  section_dir;
  logic                  busy;
  logic [7:0]            speed_cmd;
  logic                  timeout_err;

`ifdef SCHED_FAULT_CLEAR_EN
  modport master (
    output req, exit_ack, train_dir, track_condition, alert, fault_clr,
    input  grant, section_dir, busy, speed_cmd, timeout_err
  );
  modport slave (
    input  req, exit_ack, train_dir, track_condition, alert, fault_clr,
    output grant, section_dir, busy, speed_cmd, timeout_err
  );
`else
  modport master (
    output req, exit_ack, train_dir, track_condition, alert,
    input  grant, section_dir, busy, speed_cmd, timeout_err
  );
  modport slave (
    input  req, exit_ack, train_dir, track_condition, alert,
    output grant, section_dir, busy, speed_cmd, timeout_err
  );
`endif
endinterface

// File: rtl/track_section_scheduler.sv
// Round-robin arbiter for one single-line track section with occupancy timeout and exit guard.
// Define SCHED_FAULT_CLEAR_EN to allow leaving FAULT through fault_clr instead of only rst.
module track_section_scheduler #(
  parameter int NUM_TRAINS   = 4,
  parameter int MAX_OCCUPY   = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  track_section_scheduler_if.slave bus
);
  localparam int IDX_W = (NUM_TRAINS > 1) ? $clog2(NUM_TRAINS) : 1;
  localparam int OCC_W = (MAX_OCCUPY > 1) ? $clog2(MAX_OCCUPY) : 1;
  localparam int GRD_W = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, OCCUPIED, CLEAR, FAULT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_winner;
  logic [IDX_W-1:0] r_last;
  logic [OCC_W-1:0] r_occ;
  logic [GRD_W-1:0] r_guard;
  logic             r_dir;
  logic [7:0]       r_speed;

  logic [IDX_W-1:0] w_winner;
  logic             w_found;
  logic             w_exit;
  logic             w_timeout;
  logic             w_guard_done;
  logic             w_fault_clr;
  logic [7:0]       w_speed_lut;

`ifdef SCHED_FAULT_CLEAR_EN
  assign w_fault_clr = bus.fault_clr;
`else
  assign w_fault_clr = 1'b0;
`endif

  assign w_exit       = bus.exit_ack[r_winner];
  assign w_timeout    = (r_occ == OCC_W'(MAX_OCCUPY - 1));
  assign w_guard_done = (r_guard == GRD_W'(GUARD_CYCLES - 1));

  // Search starts one past the last train that completed a passage, wrapping around.
  always_comb begin : rr_search
    logic [IDX_W-1:0] cand;
    w_found  = 1'b0;
    w_winner = r_last;
    cand     = r_last;
    for (int i = 0; i < NUM_TRAINS; i++) begin
      cand = (cand == IDX_W'(NUM_TRAINS - 1)) ? '0 : cand + IDX_W'(1);
      if (!w_found && bus.req[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  always_comb begin
    w_speed_lut = 8'd0;
    case (bus.track_condition)
      2'b00:   w_speed_lut = 8'd80;
      2'b01:   w_speed_lut = 8'd50;
      2'b10:   w_speed_lut = 8'd60;
      default: w_speed_lut = 8'd40;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A train's own exit_ack takes precedence over the timeout on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_found && !bus.alert) begin
          w_next = OCCUPIED;
        end
      end
      OCCUPIED: begin
        if (w_exit) begin
          w_next = CLEAR;
        end else if (w_timeout) begin
          w_next = FAULT;
        end
      end
      CLEAR: begin
        if (w_guard_done) begin
          w_next = IDLE;
        end
      end
      FAULT: begin
        if (w_fault_clr) begin
          w_next = CLEAR;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_winner <= '0;
      r_last   <= IDX_W'(NUM_TRAINS - 1);
      r_occ    <= '0;
      r_guard  <= '0;
      r_dir    <= 1'b0;
      r_speed  <= 8'd0;
    end else begin
      if (r_state == IDLE && w_next == OCCUPIED) begin
        r_winner <= w_winner;
        r_dir    <= bus.train_dir[w_winner];
      end
      if (r_state == OCCUPIED && w_exit) begin
        r_last <= r_winner;
      end
      r_occ   <= (r_state == OCCUPIED && w_next == OCCUPIED) ? r_occ + OCC_W'(1) : '0;
      r_guard <= (r_state == CLEAR && w_next == CLEAR) ? r_guard + GRD_W'(1) : '0;
      r_speed <= (w_next == OCCUPIED && !bus.alert) ? w_speed_lut : 8'd0;
    end
  end

  assign bus.grant       = (r_state == OCCUPIED) ? (NUM_TRAINS'(1) << r_winner) : '0;
  assign bus.section_dir = r_dir;
  assign bus.busy        = (r_state != IDLE);
  assign bus.speed_cmd   = r_speed;
  assign bus.timeout_err = (r_state == FAULT);

endmodule

// File: doc/track_section_scheduler.md
# track_section_scheduler

Sequential arbiter that shares one single-line track section between up to `NUM_TRAINS` trains. It grants exclusive section access round-robin and tracks occupancy with a timeout. It enforces a guard interval between successive occupants and issues the speed command for the section. It sits between the per-train interface logic and the collision-detection / speed-selection datapath; its `alert` input is driven by the collision detector's alert output.

## Interface
- `NUM_TRAINS`, 4: number of requesters, 2..8.
- `MAX_OCCUPY`, 1000: max cycles a train may hold the section before fault.
- `GUARD_CYCLES`, 16: idle cycles enforced after a train exits, >=1.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in NUM_TRAINS: level request to enter section, one bit per train.
- `exit_ack` in NUM_TRAINS: one-cycle pulse, train has fully cleared section.
- `train_dir` in NUM_TRAINS: direction of each train (0/1).
- `track_condition` in 2: 00 uphill, 01 curve, 10 normal, 11 slippery.
- `alert` in 1: collision alert, level.
- `grant` out NUM_TRAINS: one-hot (or zero) access grant.
- `section_dir` out 1: direction latched from granted train.
- `busy` out 1: section not available (OCCUPIED, CLEAR or FAULT).
- `speed_cmd` out 8: commanded speed for granted train.
- `timeout_err` out 1: sticky occupancy-timeout fault.

## Operation
- States: IDLE, OCCUPIED, CLEAR, FAULT.
- IDLE: if `|req` and `!alert`:
  - select winner round-robin, searching from `last+1` upward and wrapping.
  - latch the winner index and `train_dir[winner]`.
  - go to OCCUPIED.
  - If `alert` is high, no grant is issued; the state stays IDLE.
- OCCUPIED:
  - `grant[winner]`=1.
  - Occupancy counter increments every cycle from 0.
  - `exit_ack[winner]` -> CLEAR, `last`<=winner.
  - `exit_ack` bits of non-granted trains are ignored.
  - Counter reaching `MAX_OCCUPY-1` without exit -> FAULT.
  - If exit and timeout occur in the same cycle, exit wins.
  - Deassertion of `req[winner]` during OCCUPIED is ignored; only `exit_ack` releases the section.
- CLEAR: `grant`=0. Guard counter runs `GUARD_CYCLES` cycles, then -> IDLE. Requests are not sampled.
- FAULT: `grant`=0, `timeout_err`=1, `speed_cmd`=0. Remains in FAULT until `rst` (see Configuration).
- `speed_cmd`:
  - In OCCUPIED with `!alert`: 80/50/60/40 for `track_condition` 00/01/10/11.
  - In OCCUPIED with `alert`: 0 (brake).
  - In all other states: 0.
- `busy` = state != IDLE.
- Counters are sized `$clog2(MAX_OCCUPY)` / `$clog2(GUARD_CYCLES+1)` bits. Neither counter may wrap.

## Timing
- Reset values:
  - state IDLE.
  - `grant`=0, `section_dir`=0, `busy`=0, `speed_cmd`=0, `timeout_err`=0.
  - `last`=NUM_TRAINS-1, so train 0 has first priority.
  - All counters 0.
- `grant` rises exactly 1 cycle after the `req` edge sampled in IDLE.
- `speed_cmd` and `section_dir` are valid in the same cycle as `grant`.
- `speed_cmd` follows `track_condition`/`alert` with 1 cycle of registered latency.
- `exit_ack` sampled at edge N: `grant` is 0 at N+1. The earliest next `grant` is at N+1+GUARD_CYCLES+1.
- Timeout: `grant` first high at cycle G with no exit -> FAULT entered at G+MAX_OCCUPY. `timeout_err` is high from that cycle on.
- `rst` mid-occupancy: all outputs return to reset values at the next edge, and the round-robin pointer is reset.

## Configuration
- `SCHED_FAULT_CLEAR_EN` defined:
  - adds input port `fault_clr` (1 bit).
  - In FAULT, `fault_clr`=1 -> CLEAR next cycle; `timeout_err` is cleared on that transition.
  - The full guard interval applies before IDLE.
- Undefined: no `fault_clr` port; FAULT exits only via `rst`.

## Test plan
- Reset, `req`=4'b0001, `track_condition`=10 -> cycle+1: `grant`=0001, `speed_cmd`=60, `busy`=1. `exit_ack`=0001 -> `grant`=0; IDLE after 16 guard cycles.
- `req`=4'b1111 held, each granted train pulses `exit_ack` 5 cycles after grant -> grant order 0001, 0010, 0100, 1000, 0001.
- During OCCUPIED, assert `alert` for 3 cycles -> `speed_cmd`=0 for those 3 cycles (1-cycle lag); `grant` unchanged. `alert` high in IDLE with `req` set -> no grant.
- `MAX_OCCUPY`=10, grant with no exit -> FAULT 10 cycles after grant: `timeout_err`=1, `grant`=0, new `req` ignored. With `SCHED_FAULT_CLEAR_EN`, `fault_clr` -> IDLE after guard.
- `exit_ack`=0100 while train 1 holds grant -> ignored. `exit_ack` coinciding with the timeout cycle -> CLEAR, no fault.
- `rst` asserted mid-OCCUPIED with `req`=1000 -> all outputs 0. After release, `req`=1001 -> train 0 granted first.
